// File: rtl/otp_pad_scheduler.sv
// otp_pad_scheduler: shares a one-time-pad store between an encrypt requester
// and a decrypt requester. The two request streams are arbitrated round-robin.
// Encrypt takes the current LFSR byte as the pad, stores it in the next slot and
// returns pad^plaintext. Decrypt XORs the stored pad with the ciphertext and then
// clears the slot, so each pad is used at most once.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   enc_req/enc_data     encrypt request and plaintext, held until enc_gnt
//   enc_gnt              one-cycle pulse: encrypt accepted
//   dec_req/dec_data/dec_idx  decrypt request, ciphertext and slot, held until dec_gnt
//   dec_gnt              one-cycle pulse: decrypt accepted
//   prn_in               current LFSR output (pad source)
//   prn_adv              one-cycle pulse: pad consumed, LFSR may advance
//   out_valid            one-cycle pulse: out_data/out_idx/out_err valid
//   out_data/out_idx/out_err  result, slot index, decrypt-of-empty-slot flag
//   full                 next write slot still holds an unused pad
//   occupancy            number of slots holding an unused pad
module otp_pad_scheduler #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_req,
  input  logic [DATA_W-1:0] enc_data,
  output logic              enc_gnt,
  input  logic              dec_req,
  input  logic [DATA_W-1:0] dec_data,
  input  logic [IDX_W-1:0]  dec_idx,
  output logic              dec_gnt,
  input  logic [DATA_W-1:0] prn_in,
  output logic              prn_adv,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_err,
  output logic              full,
  output logic [IDX_W:0]    occupancy
);

  localparam int unsigned OCC_W = IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_DEC  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic                rr_q, rr_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   pad_q, pad_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic                enc_gnt_d, dec_gnt_d, prn_adv_d, out_valid_d, out_err_d, full_d;
  logic [DATA_W-1:0]   out_data_d;
  logic [IDX_W-1:0]    out_idx_d;
  logic [OCC_W-1:0]    occ_d;
  logic                enc_elig, take_enc, take_dec;

  // State, storage and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rr_q      <= 1'b0;
      valid_q   <= '0;
      mem_q     <= '{default: '0};
      data_q    <= '0;
      pad_q     <= '0;
      idx_q     <= '0;
      enc_gnt   <= 1'b0;
      dec_gnt   <= 1'b0;
      prn_adv   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_err   <= 1'b0;
      full      <= 1'b0;
      occupancy <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rr_q      <= rr_d;
      valid_q   <= valid_d;
      mem_q     <= mem_d;
      data_q    <= data_d;
      pad_q     <= pad_d;
      idx_q     <= idx_d;
      enc_gnt   <= enc_gnt_d;
      dec_gnt   <= dec_gnt_d;
      prn_adv   <= prn_adv_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_idx   <= out_idx_d;
      out_err   <= out_err_d;
      full      <= full_d;
      occupancy <= occ_d;
    end
  end

  // Arbitration, slot update and result generation
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rr_d        = rr_q;
    valid_d     = valid_q;
    mem_d       = mem_q;
    data_d      = data_q;
    pad_d       = pad_q;
    idx_d       = idx_q;
    enc_gnt_d   = 1'b0;
    dec_gnt_d   = 1'b0;
    prn_adv_d   = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data;
    out_idx_d   = out_idx;
    out_err_d   = out_err;
    occ_d       = occupancy;
    enc_elig    = 1'b0;
    take_enc    = 1'b0;
    take_dec    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Encrypt may not overwrite a pad that has not been consumed yet
        enc_elig = enc_req & ~valid_q[wr_ptr_q];
        take_enc = enc_elig & (~dec_req | ~rr_q);
        take_dec = dec_req & ~take_enc;
        if (take_enc) begin
          enc_gnt_d = 1'b1;
          prn_adv_d = 1'b1;
          data_d    = enc_data;
          pad_d     = prn_in;
          state_d   = S_ENC;
          if (dec_req) rr_d = 1'b1;
        end else if (take_dec) begin
          dec_gnt_d = 1'b1;
          data_d    = dec_data;
          idx_d     = dec_idx;
          state_d   = S_DEC;
          if (enc_elig) rr_d = 1'b0;
        end
      end
      S_ENC: begin
        mem_d[wr_ptr_q]   = pad_q;
        valid_d[wr_ptr_q] = 1'b1;
        out_data_d        = pad_q ^ data_q;
        out_idx_d         = wr_ptr_q;
        out_err_d         = 1'b0;
        out_valid_d       = 1'b1;
        wr_ptr_d          = wr_ptr_q + IDX_W'(1);
        occ_d             = occupancy + OCC_W'(1);
        state_d           = S_IDLE;
      end
      S_DEC: begin
        if (valid_q[idx_q]) begin
          out_data_d     = mem_q[idx_q] ^ data_q;
          out_err_d      = 1'b0;
          mem_d[idx_q]   = '0;
          valid_d[idx_q] = 1'b0;
          occ_d          = occupancy - OCC_W'(1);
        end else begin
          out_data_d = '0;
          out_err_d  = 1'b1;
        end
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    full_d = valid_d[wr_ptr_d];
  end

endmodule
